// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port; 1-cycle grant latency, one idle bubble per burst.
// fifo_full backpressures req_ready/fifo_w_en combinationally; define FIFO_ARB_PRIO_EN to give requester 0 priority at grant time.
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [N_REQ-1:0]              req_last,
  output logic [N_REQ-1:0]              req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic                          busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam int BCW = $clog2(BURST_MAX + 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_owner;
  logic [IDW-1:0]  r_rr_ptr;
  logic [BCW-1:0]  r_beat_cnt;

  logic [DATA_WIDTH-1:0] w_slice [N_REQ];
  logic [IDW-1:0]        w_winner;
  logic                  w_any;
  logic                  w_busy;
  logic                  w_own_vld;
  logic                  w_own_last;
  logic                  w_xfer;
  logic                  w_end;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign w_slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search order starts one past the last owner, wrapping modulo N_REQ.
  always_comb begin
    logic [IDW:0] cand;
    w_winner = '0;
    w_any    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N_REQ)) cand = cand - (IDW+1)'(N_REQ);
      if (!w_any && req_valid[cand[IDW-1:0]]) begin
        w_winner = cand[IDW-1:0];
        w_any    = 1'b1;
      end
    end
`ifdef FIFO_ARB_PRIO_EN
    if (req_valid[0]) begin
      w_winner = '0;
      w_any    = 1'b1;
    end
`endif
  end

  assign w_busy     = (r_state == S_BURST);
  assign w_own_vld  = req_valid[r_owner];
  assign w_own_last = req_last[r_owner];
  assign w_xfer     = w_busy & w_own_vld & ~fifo_full;
  // A full FIFO with the owner still valid stalls; only a dropped valid releases.
  assign w_end      = w_busy & (~w_own_vld |
                      (w_xfer & (w_own_last | (r_beat_cnt == BCW'(BURST_MAX - 1)))));

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = w_busy & ~fifo_full & (r_owner == IDW'(i));
    end
  end

  assign fifo_w_en = w_xfer;
  assign fifo_data = rst_n ? w_slice[r_owner] : '0;
  assign busy      = w_busy;
  assign grant_id  = w_busy ? r_owner : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_beat_cnt <= '0;
      r_rr_ptr   <= IDW'(N_REQ - 1);
    end else if (r_state == S_IDLE) begin
      if (w_any) begin
        r_owner    <= w_winner;
        r_beat_cnt <= '0;
        r_state    <= S_BURST;
      end
    end else begin
      if (w_xfer) r_beat_cnt <= r_beat_cnt + BCW'(1);
      if (w_end) begin
        r_state  <= S_IDLE;
        r_rr_ptr <= r_owner;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboarded bench for fifo_wr_arbiter: per-requester word queues plus a grant-rule reference model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int BM = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [N*W-1:0] req_data;
  logic           fifo_full, fifo_w_en;
  logic [W-1:0]   fifo_data;
  logic [1:0]     grant_id;
  logic           busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(W), .BURST_MAX(BM)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_w_en(fifo_w_en), .fifo_data(fifo_data), .grant_id(grant_id), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  logic [8:0] src_q [N][$];
  logic [7:0] exp_q [N][$];
  int         grant_log[$];
  int         len_log[$];
  logic [N-1:0] took = '0;
  logic [N-1:0] mute = '0;
  int vprob = 100;
  int full_prob = 0;
  bit force_full = 1'b0;

  bit m_busy = 1'b0;
  int m_owner = 0, m_beats = 0, m_rr = N - 1, m_pick;
  logic [N-1:0] m_er;
  bit prev_busy = 1'b0;
  int cur_len = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int pick(logic [N-1:0] v, int rr);
`ifdef FIFO_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic push(int r, logic [7:0] d, bit l);
    src_q[r].push_back({l, d});
    exp_q[r].push_back(d);
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic drain(int budget);
    int n = 0;
    bit pend;
    do begin
      @(negedge clk); #1;
      pend = busy;
      for (int i = 0; i < N; i++) if (src_q[i].size() > 0) pend = 1'b1;
      n++;
    end while (pend && n < budget);
    if (pend) begin
      total++; bad++;
      $display("FAIL drain_timeout: still pending after %0d cycles", budget);
    end
    cyc(1);
  endtask

  task automatic wait_exp(int r, int sz, int budget);
    int n = 0;
    while (exp_q[r].size() != sz && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_q[r].size() != sz) begin
      total++; bad++;
      $display("FAIL wait_exp_timeout: req %0d has %0d words left, wanted %0d", r, exp_q[r].size(), sz);
    end
  endtask

  // Producers: present the head word of each queue, random gaps on valid.
  initial begin
    req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (took[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0 && !mute[i] && $urandom_range(99) < vprob) begin
          req_valid[i] = 1'b1;
          req_data[i*W +: W] = src_q[i][0][7:0];
          req_last[i] = src_q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      fifo_full = force_full || ($urandom_range(99) < full_prob);
    end
  end

  always @(negedge clk) took = req_valid & req_ready & {N{rst_n}};

  // Monitor: compare outputs with the model, pop written words, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_owner = 0; m_beats = 0; m_rr = N - 1;
      prev_busy = 1'b0; cur_len = 0;
    end else begin
      m_er = (m_busy && !fifo_full) ? (N'(1) << m_owner) : '0;
      chk("busy", busy, m_busy);
      chk("grant_id", grant_id, m_busy ? m_owner : 0);
      chk("req_ready", req_ready, m_er);
      chk("fifo_w_en", fifo_w_en, m_busy && req_valid[m_owner] && !fifo_full);
      if (fifo_w_en) begin
        if (exp_q[m_owner].size() == 0) begin
          total++; bad++;
          $display("FAIL extra_write: data %0h from req %0d with nothing outstanding", fifo_data, m_owner);
        end else begin
          chk($sformatf("fifo_data_req%0d", m_owner), fifo_data, exp_q[m_owner].pop_front());
        end
      end
      if (busy && !prev_busy) begin
        grant_log.push_back(int'(grant_id));
        cur_len = 0;
      end
      if (fifo_w_en) cur_len++;
      if (!busy && prev_busy) len_log.push_back(cur_len);
      prev_busy = busy;

      if (!m_busy) begin
        m_pick = pick(req_valid, m_rr);
        if (m_pick >= 0) begin
          m_busy = 1'b1; m_owner = m_pick; m_beats = 0;
        end
      end else if (!req_valid[m_owner]) begin
        m_busy = 1'b0; m_rr = m_owner;
      end else if (!fifo_full) begin
        m_beats++;
        if (req_last[m_owner] || m_beats == BM) begin
          m_busy = 1'b0; m_rr = m_owner;
        end
      end
    end
  end

  initial begin
    int gb, lb;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_w_en", fifo_w_en, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_data", fifo_data, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    cyc(2);

    // Round robin, all requesters valid with 1-word bursts.
    for (int rep = 0; rep < 2; rep++)
      for (int r = 0; r < N; r++) push(r, 8'($urandom), 1'b1);
    drain(200);
    chk("rr_bursts", grant_log.size(), 8);
    if (grant_log.size() >= 6)
      for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), grant_log[i], i % 4);

    // Single requester 2, three words.
    gb = grant_log.size(); lb = len_log.size();
    push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(2, 8'hA3, 1'b1);
    drain(100);
    chk("single_grants", grant_log.size(), gb + 1);
    if (grant_log.size() > gb) chk("single_owner", grant_log[gb], 2);
    if (len_log.size() > lb) chk("single_len", len_log[lb], 3);

    // Burst cap: 6 words without last.
    gb = grant_log.size(); lb = len_log.size();
    for (int i = 0; i < 6; i++) push(0, 8'(8'h30 + i), 1'b0);
    drain(100);
    chk("cap_bursts", len_log.size(), lb + 2);
    if (len_log.size() >= lb + 2) begin
      chk("cap_len0", len_log[lb], BM);
      chk("cap_len1", len_log[lb + 1], 2);
    end

    // Full stall of 5 cycles mid-burst of requester 1.
    gb = grant_log.size(); lb = len_log.size();
    for (int i = 0; i < 4; i++) push(1, 8'(8'h50 + i), i == 3);
    wait_exp(1, 3, 50);
    force_full = 1'b1;
    repeat (5) @(posedge clk);
    #2 force_full = 1'b0;
    drain(100);
    chk("stall_grants", grant_log.size(), gb + 1);
    if (len_log.size() > lb) chk("stall_len", len_log[lb], 4);

    // Priority case: rr_ptr at 0, requesters 0 and 2 valid together.
    push(0, 8'h60, 1'b1);
    drain(50);
    gb = grant_log.size();
    push(0, 8'h61, 1'b1); push(2, 8'h62, 1'b1);
    drain(50);
    if (grant_log.size() >= gb + 2) begin
`ifdef FIFO_ARB_PRIO_EN
      chk("prio_first", grant_log[gb], 0);
      chk("prio_second", grant_log[gb + 1], 2);
`else
      chk("prio_first", grant_log[gb], 2);
      chk("prio_second", grant_log[gb + 1], 0);
`endif
    end else chk("prio_grants", grant_log.size(), gb + 2);

    // Release: requester 3 drops valid after its first word.
    lb = len_log.size();
    push(3, 8'h71, 1'b0); push(3, 8'h72, 1'b0); push(3, 8'h73, 1'b1);
    wait_exp(3, 2, 50);
    mute[3] = 1'b1;
    cyc(3);
    chk("release_idle", busy, 0);
    if (len_log.size() > lb) chk("release_len", len_log[lb], 1);
    mute[3] = 1'b0;
    drain(50);
    if (len_log.size() > lb + 1) chk("release_rest_len", len_log[lb + 1], 2);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 3; i++) push(1, 8'(8'h81 + i), i == 2);
    begin
      int n = 0;
      while (!busy && n < 50) begin @(negedge clk); #1; n++; end
      chk("rstmid_busy_before", busy, 1);
    end
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("rstmid_req_ready", req_ready, 0);
    chk("rstmid_w_en", fifo_w_en, 0);
    chk("rstmid_grant_id", grant_id, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_fifo_data", fifo_data, 0);
    for (int i = 0; i < N; i++) begin src_q[i].delete(); exp_q[i].delete(); end
    cyc(2);
    @(posedge clk); #3 rst_n = 1'b1;
    cyc(1);
    gb = grant_log.size();
    push(3, 8'h91, 1'b1); push(0, 8'h90, 1'b1);
    drain(50);
    if (grant_log.size() > gb) chk("post_rst_first", grant_log[gb], 0);

    // Random traffic with random backpressure.
    vprob = 75; full_prob = 25;
    repeat (400) begin
      cyc(1);
      for (int r = 0; r < N; r++)
        if ($urandom_range(4) == 0 && src_q[r].size() < 6)
          push(r, 8'($urandom), $urandom_range(3) == 0);
    end
    vprob = 100; full_prob = 0;
    drain(3000);
    for (int r = 0; r < N; r++) chk($sformatf("rand_left_req%0d", r), exp_q[r].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
